ysyx_24100005_register_file: RTL and testbench

YSYX_24100005_REGISTER_FILE -- requirements
Module: ysyx_24100005_register_file

---
 rtl/ysyx_24100005_register_file.sv | 66 ++++++
 tb/tb_ysyx_24100005_register_file.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_register_file.sv
// ysyx_24100005_register_file
// Register file with two combinational read ports and one synchronous write
// port. Entry 0 is hardwired to zero. The active-low reset clears every entry
// immediately, without waiting for a clock edge.
//
// Optional feature: define YSYX_24100005_RF_BYPASS_EN to forward the write data
// to a read port that addresses the entry being written in the same cycle. The
// stored state behaves the same way whether or not the macro is defined.

module ysyx_24100005_register_file #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata2
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // Next-state contents: hold everything, apply at most one write, and keep entry 0 at zero
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wen && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    // Storage: cleared the moment reset goes low; a clock edge during reset has no effect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: combinational, independent, with index 0 always reading zero
    always_comb begin
        rdata  = (raddr  == '0) ? '0 : regs_q[raddr];
        rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
`ifdef YSYX_24100005_RF_BYPASS_EN
        if (wen && rst && (waddr != '0)) begin
            if (raddr == waddr) begin
                rdata = wdata;
            end
            if (raddr2 == waddr) begin
                rdata2 = wdata;
            end
        end
`endif
    end

endmodule

// File: tb/tb_ysyx_24100005_register_file.sv
// tb_ysyx_24100005_register_file
// Directed vectors for the register file. The stimulus process queues each
// expected read value and then raises a sample event. A separate monitor
// process responds to that event by popping the queue and comparing the DUT
// outputs against it.

module tb_ysyx_24100005_register_file;

    logic        clk;
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    typedef struct {
        bit          port;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    ysyx_24100005_register_file #(
        .ADDR_WIDTH(5),
        .DATA_WIDTH(32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata),
        .raddr2(raddr2),
        .rdata2(rdata2)
    );

    // 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: on each sample event, compare every queued expectation with the live read ports
    initial begin
        forever begin
            @(sample_ev);
            while (sb_q.size() != 0) begin
                exp_t e;
                logic [31:0] act;
                e   = sb_q.pop_front();
                act = e.port ? rdata2 : rdata;
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    // Drive all DUT inputs at once
    task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [4:0] ra, input logic [4:0] ra2);
        wen    = w;
        waddr  = wa;
        wdata  = wd;
        raddr  = ra;
        raddr2 = ra2;
    endtask

    // Queue an expected value for read port A (port=0) or read port B (port=1)
    task automatic checkOutput(input bit port, input logic [31:0] exp, input string name);
        exp_t e;
        e.port = port;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Let the inputs settle, then tell the monitor to sample
    task automatic sampleNow();
        #1;
        ->sample_ev;
        #1;
    endtask

    // Write one entry: drive at the falling edge, commit on the rising edge, drop wen afterwards
    task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        applyStimulus(1'b1, a, d, raddr, raddr2);
        @(negedge clk);
        wen = 1'b0;
    endtask

    initial begin
        logic [31:0] exp7;
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd31);

        // Values read while the initial reset is held
        #2;
        checkOutput(0, 32'h0, "reset_r0");
        checkOutput(1, 32'h0, "reset_r31");
        sampleNow();

        @(negedge clk);
        rst = 1'b1;

        // Fill entries 1..31 so the register file holds known non-zero contents
        for (int i = 1; i < 32; i++) begin
            writeReg(i[4:0], 32'hA500_0000 | i);
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd10, 5'd31);
        checkOutput(0, 32'hA500_000A, "fill_r10");
        checkOutput(1, 32'hA500_001F, "fill_r31");
        sampleNow();

        // Write 5, then read it on both ports
        writeReg(5'd5, 32'h8000_0004);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        checkOutput(0, 32'h8000_0004, "wr5_portA");
        checkOutput(1, 32'h8000_0004, "wr5_portB");
        sampleNow();

        // A write to index 0 is discarded
        writeReg(5'd0, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        checkOutput(0, 32'h0, "zero_portA");
        checkOutput(1, 32'h0, "zero_portB");
        sampleNow();

        // Entry 0 must never forward, even while a write to it is pending
        @(negedge clk);
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        checkOutput(0, 32'h0, "zero_pending_A");
        checkOutput(1, 32'h0, "zero_pending_B");
        sampleNow();
        @(negedge clk);
        wen = 1'b0;

        // With wen low, the entry does not change
        writeReg(5'd3, 32'h1234_5678);
        @(negedge clk);
        applyStimulus(1'b0, 5'd3, 32'hDEAD_BEEF, 5'd3, 5'd4);
        @(negedge clk);
        checkOutput(0, 32'h1234_5678, "wen0_r3");
        checkOutput(1, 32'hA500_0004, "wen0_r4");
        sampleNow();

        // Read of the write target in the same cycle, sampled before and after the edge
        writeReg(5'd7, 32'h0000_0011);
        @(negedge clk);
        applyStimulus(1'b1, 5'd7, 32'h0000_0022, 5'd7, 5'd7);
`ifdef YSYX_24100005_RF_BYPASS_EN
        exp7 = 32'h0000_0022;
`else
        exp7 = 32'h0000_0011;
`endif
        checkOutput(0, exp7, "same_cycle_A");
        checkOutput(1, exp7, "same_cycle_B");
        sampleNow();
        @(negedge clk);
        wen = 1'b0;
        checkOutput(0, 32'h0000_0022, "after_edge_A");
        checkOutput(1, 32'h0000_0022, "after_edge_B");
        sampleNow();

        // Reset asserted between edges while a write is pending: contents clear at once
        @(negedge clk);
        applyStimulus(1'b1, 5'd9, 32'h0000_00AB, 5'd9, 5'd5);
        #1;
        rst = 1'b0;
        checkOutput(0, 32'h0, "midreset_r9");
        checkOutput(1, 32'h0, "midreset_r5");
        sampleNow();
        for (int i = 1; i < 32; i++) begin
            raddr  = i[4:0];
            raddr2 = 5'(32 - i);
            checkOutput(0, 32'h0, "reset_sweep_A");
            checkOutput(1, 32'h0, "reset_sweep_B");
            sampleNow();
        end

        // A rising edge while reset is held must not commit the write
        raddr = 5'd9;
        @(posedge clk);
        #1;
        checkOutput(0, 32'h0, "reset_edge_r9");
        sampleNow();

        // Release reset with wen low; entry 9 stays cleared
        @(negedge clk);
        wen = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput(0, 32'h0, "post_reset_r9");
        checkOutput(1, 32'h0, "post_reset_r7");
        raddr2 = 5'd7;
        sampleNow();

        // Normal writes resume after reset
        writeReg(5'd9, 32'h0000_00AB);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        checkOutput(0, 32'h0000_00AB, "resume_A");
        checkOutput(1, 32'h0000_00AB, "resume_B");
        sampleNow();

        // Bounded wait for the monitor to drain the scoreboard
        for (int t = 0; t < 100; t++) begin
            if (sb_q.size() == 0) break;
            #1;
        end
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
